// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one multiplier among three requesters
// Optional WAIT watchdog and err output: define MULT_ARBITER_TIMEOUT_EN.

module mult_arbiter #(
  parameter int M_BITS   = 12,
  parameter int N_BITS   = 8,
  parameter int MAX_WAIT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               req,
  input  logic [M_BITS-1:0]        mpd0,
  input  logic [M_BITS-1:0]        mpd1,
  input  logic [M_BITS-1:0]        mpd2,
  input  logic [N_BITS-1:0]        mpr0,
  input  logic [N_BITS-1:0]        mpr1,
  input  logic [N_BITS-1:0]        mpr2,
  output logic [2:0]               gnt,
  output logic [2:0]               done,
  output logic [M_BITS+N_BITS-1:0] result,
  output logic [M_BITS-1:0]        m_mpd,
  output logic [N_BITS-1:0]        m_mpr,
  output logic                     m_start,
  input  logic                     m_busy,
  input  logic [M_BITS+N_BITS-1:0] m_answer
`ifdef MULT_ARBITER_TIMEOUT_EN
  ,
  output logic                     err
`endif
);

  localparam int P_BITS = M_BITS + N_BITS;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          gnt_q, gnt_d;
  logic [2:0]          done_q, done_d;
  logic [1:0]          idx_q, idx_d;
  logic [1:0]          last_q, last_d;
  logic [P_BITS-1:0]   result_q, result_d;
  logic [M_BITS-1:0]   mpd_q, mpd_d;
  logic [N_BITS-1:0]   mpr_q, mpr_d;
  logic                start_q, start_d;
  logic                first_q, first_d;

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("MAX_WAIT must be at least 1");
  end

`ifdef MULT_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
`endif

  logic [1:0]          rr_base, cand, win_idx;
  logic                win_found;
  logic [M_BITS-1:0]   sel_mpd;
  logic [N_BITS-1:0]   sel_mpr;

  // Search starts one past the last winner and wraps modulo 3.
  always_comb begin
    rr_base   = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    cand      = rr_base;
    win_idx   = rr_base;
    win_found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    end
  end

  always_comb begin
    sel_mpd = mpd0;
    sel_mpr = mpr0;
    case (win_idx)
      2'd1: begin
        sel_mpd = mpd1;
        sel_mpr = mpr1;
      end
      2'd2: begin
        sel_mpd = mpd2;
        sel_mpr = mpr2;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    last_d   = last_q;
    result_d = result_q;
    mpd_d    = mpd_q;
    mpr_d    = mpr_q;
    first_d  = first_q;
    start_d  = 1'b0;
    done_d   = 3'b000;
`ifdef MULT_ARBITER_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = LAUNCH;
          gnt_d   = 3'b001 << win_idx;
          idx_d   = win_idx;
          mpd_d   = sel_mpd;
          mpr_d   = sel_mpr;
          start_d = 1'b1;
        end
      end
      LAUNCH: begin
        state_d = WAIT;
        first_d = 1'b1;
`ifdef MULT_ARBITER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        first_d = 1'b0;
        // The multiplier cannot raise busy until a cycle after start.
        if (!first_q && !m_busy) begin
          state_d  = DONE;
          result_d = m_answer;
          done_d   = gnt_q;
          last_d   = idx_q;
        end
`ifdef MULT_ARBITER_TIMEOUT_EN
        else if (m_busy) begin
          if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
            state_d  = DONE;
            result_d = '1;
            done_d   = gnt_q;
            last_d   = idx_q;
            err_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= 3'b000;
      done_q   <= 3'b000;
      idx_q    <= 2'd0;
      last_q   <= 2'd2;
      result_q <= '0;
      mpd_q    <= '0;
      mpr_q    <= '0;
      start_q  <= 1'b0;
      first_q  <= 1'b0;
`ifdef MULT_ARBITER_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      result_q <= result_d;
      mpd_q    <= mpd_d;
      mpr_q    <= mpr_d;
      start_q  <= start_d;
      first_q  <= first_d;
`ifdef MULT_ARBITER_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign result  = result_q;
  assign m_mpd   = mpd_q;
  assign m_mpr   = mpr_q;
  assign m_start = start_q;
`ifdef MULT_ARBITER_TIMEOUT_EN
  assign err     = err_q;
`endif

endmodule
